// File: rtl/i2c_txn_scheduler_if.sv
// Engine-side bus of the I2C transaction scheduler.
// The scheduler (master) drives one transaction request at a time: a single-cycle
// i2c_start pulse plus the slave/subaddress/direction/data/length fields, which
// stay stable until the engine answers. The engine (slave) returns a one-cycle
// i2c_done pulse together with i2c_nack and up to four bytes of i2c_rdata.
interface i2c_txn_scheduler_if;
  logic        i2c_start;
  logic [6:0]  i2c_slave;
  logic [6:0]  i2c_sub;
  logic        i2c_rw;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_nbytes;
  logic        i2c_done;
  logic        i2c_nack;
  logic [31:0] i2c_rdata;

  modport master (
    output i2c_start, i2c_slave, i2c_sub, i2c_rw, i2c_wdata, i2c_nbytes,
    input  i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_start, i2c_slave, i2c_sub, i2c_rw, i2c_wdata, i2c_nbytes,
    output i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/i2c_txn_scheduler.sv
// I2C transaction scheduler.
// Arbitrates between one-shot PC requests and periodic sensor polls, issues one
// transaction at a time to an I2C engine and collects the results.
// Ports:
//   FSM_Clk, rst_n     sole clock, asynchronous active-low reset
//   PCControl          rising edge requests one PC transaction (fields pc_*)
//   pc_slave/pc_sub/pc_rw/pc_wdata/pc_nbytes   PC transaction fields
//   poll_en            enables automatic polling every POLL_PERIOD cycles
//   eng                engine bus (start/fields out, done/nack/rdata in)
//   pc_busy, pc_done   PC request pending/in flight, one-cycle completion pulse
//   pc_rdata           last PC read result
//   acc_data/mag_data  last successful accelerometer/magnetometer poll results
//   err                sticky {timeout, nack}, cleared by an accepted PC request
module i2c_txn_scheduler #(
  parameter int         POLL_PERIOD = 1000,
  parameter int         TIMEOUT     = 4095,
  parameter logic [6:0] ACC_ADDR    = 7'h19,
  parameter logic [6:0] MAG_ADDR    = 7'h1E,
  parameter logic [6:0] ACC_SUB     = 7'h28,
  parameter logic [6:0] MAG_SUB     = 7'h03
) (
  input  logic        FSM_Clk,
  input  logic        rst_n,
  input  logic        PCControl,
  input  logic [6:0]  pc_slave,
  input  logic [6:0]  pc_sub,
  input  logic        pc_rw,
  input  logic [7:0]  pc_wdata,
  input  logic [7:0]  pc_nbytes,
  input  logic        poll_en,
  i2c_txn_scheduler_if.master eng,
  output logic        pc_busy,
  output logic        pc_done,
  output logic [31:0] pc_rdata,
  output logic [31:0] acc_data,
  output logic [31:0] mag_data,
  output logic [1:0]  err
);

  localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} stateT;

  stateT       state;
  logic        pcCtlPrev;
  logic        pcPend;
  logic        pollPend;
  logic        pollMag;      // 0: next poll targets accelerometer, 1: magnetometer
  logic        curIsPc;      // owner of the transaction currently in flight
  logic [6:0]  pcSlaveL;
  logic [6:0]  pcSubL;
  logic        pcRwL;
  logic [7:0]  pcWdataL;
  logic [7:0]  pcNbytesL;
  logic [CW-1:0] pollCnt;
  logic [WW-1:0] waitCnt;    // cycles elapsed since i2c_start
  logic [31:0] capData;
  logic        capNack;

  logic        startR;
  logic [6:0]  slaveR;
  logic [6:0]  subR;
  logic        rwR;
  logic [7:0]  wdataR;
  logic [7:0]  nbytesR;
  logic        pcDoneR;
  logic [31:0] pcRdataR;
  logic [31:0] accR;
  logic [31:0] magR;
  logic [1:0]  errR;

  logic pcInFlight;
  logic pcEdge;
  logic pollWrap;

  assign pcInFlight = curIsPc && (state != IDLE);
  assign pcEdge     = PCControl && !pcCtlPrev;
  assign pollWrap   = poll_en && (pollCnt == POLL_LAST);

  function automatic logic [7:0] clampBytes(input logic [7:0] n);
    if (n == 8'd0)      return 8'd1;
    else if (n > 8'd4)  return 8'd4;
    else                return n;
  endfunction

  always_ff @(posedge FSM_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcCtlPrev <= 1'b0;
      pcPend    <= 1'b0;
      pollPend  <= 1'b0;
      pollMag   <= 1'b0;
      curIsPc   <= 1'b0;
      pcSlaveL  <= '0;
      pcSubL    <= '0;
      pcRwL     <= 1'b0;
      pcWdataL  <= '0;
      pcNbytesL <= '0;
      pollCnt   <= '0;
      waitCnt   <= '0;
      capData   <= '0;
      capNack   <= 1'b0;
      startR    <= 1'b0;
      slaveR    <= '0;
      subR      <= '0;
      rwR       <= 1'b0;
      wdataR    <= '0;
      nbytesR   <= '0;
      pcDoneR   <= 1'b0;
      pcRdataR  <= '0;
      accR      <= '0;
      magR      <= '0;
      errR      <= '0;
    end else begin
      pcCtlPrev <= PCControl;
      startR    <= 1'b0;
      pcDoneR   <= 1'b0;

      if (!poll_en || pollWrap) pollCnt <= '0;
      else                      pollCnt <= pollCnt + 1'b1;

      // Only one PC request can be outstanding; later edges are dropped.
      if (pcEdge && !pcPend && !pcInFlight) begin
        pcPend    <= 1'b1;
        pcSlaveL  <= pc_slave;
        pcSubL    <= pc_sub;
        pcRwL     <= pc_rw;
        pcWdataL  <= pc_wdata;
        pcNbytesL <= pc_nbytes;
        errR      <= 2'b00;
      end

      case (state)
        IDLE: begin
          if (pcPend) begin
            curIsPc <= 1'b1;
            pcPend  <= 1'b0;
            startR  <= 1'b1;
            slaveR  <= pcSlaveL;
            subR    <= pcSubL;
            rwR     <= pcRwL;
            wdataR  <= pcWdataL;
            nbytesR <= clampBytes(pcNbytesL);
            state   <= ISSUE;
          end else if (pollPend && poll_en) begin
            curIsPc  <= 1'b0;
            pollPend <= 1'b0;
            startR   <= 1'b1;
            slaveR   <= pollMag ? MAG_ADDR : ACC_ADDR;
            subR     <= pollMag ? MAG_SUB : ACC_SUB;
            rwR      <= 1'b1;
            wdataR   <= 8'h00;
            nbytesR  <= 8'd4;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= WW'(1);
          state   <= WAIT;
        end
        WAIT: begin
          if (eng.i2c_done) begin
            capData <= eng.i2c_rdata;
            capNack <= eng.i2c_nack;
            state   <= CAPTURE;
          end else if (waitCnt >= WAIT_LAST) begin
            errR[1] <= 1'b1;
            state   <= IDLE;
            if (curIsPc) pcDoneR <= 1'b1;
            else         pollMag <= ~pollMag;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        CAPTURE: begin
          // pollMag still names the target of this poll; it flips on exit.
          if (capNack)      errR[0] <= 1'b1;
          else if (curIsPc) begin
            if (rwR) pcRdataR <= capData;
          end
          else if (pollMag) magR <= capData;
          else              accR <= capData;
          state <= IDLE;
          if (curIsPc) pcDoneR <= 1'b1;
          else         pollMag <= ~pollMag;
        end
        default: state <= IDLE;
      endcase

      // A wrap only raises the flag, so repeated wraps never queue twice.
      if (!poll_en)      pollPend <= 1'b0;
      else if (pollWrap) pollPend <= 1'b1;
    end
  end

  assign eng.i2c_start  = startR;
  assign eng.i2c_slave  = slaveR;
  assign eng.i2c_sub    = subR;
  assign eng.i2c_rw     = rwR;
  assign eng.i2c_wdata  = wdataR;
  assign eng.i2c_nbytes = nbytesR;
  assign pc_busy        = pcPend | pcInFlight;
  assign pc_done        = pcDoneR;
  assign pc_rdata       = pcRdataR;
  assign acc_data       = accR;
  assign mag_data       = magR;
  assign err            = errR;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed testbench for i2c_txn_scheduler (POLL_PERIOD=8, TIMEOUT=16).
// A behavioural engine answers each i2c_start after engDelay cycles.
`timescale 1ns/1ps
module tb_i2c_txn_scheduler;
  logic        FSM_Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCControl = 1'b0;
  logic [6:0]  pc_slave = '0;
  logic [6:0]  pc_sub = '0;
  logic        pc_rw = 1'b0;
  logic [7:0]  pc_wdata = '0;
  logic [7:0]  pc_nbytes = '0;
  logic        poll_en = 1'b0;
  logic        pc_busy;
  logic        pc_done;
  logic [31:0] pc_rdata;
  logic [31:0] acc_data;
  logic [31:0] mag_data;
  logic [1:0]  err;

  i2c_txn_scheduler_if bus();

  i2c_txn_scheduler #(.POLL_PERIOD(8), .TIMEOUT(16)) dut (
    .FSM_Clk(FSM_Clk), .rst_n(rst_n), .PCControl(PCControl),
    .pc_slave(pc_slave), .pc_sub(pc_sub), .pc_rw(pc_rw),
    .pc_wdata(pc_wdata), .pc_nbytes(pc_nbytes), .poll_en(poll_en),
    .eng(bus), .pc_busy(pc_busy), .pc_done(pc_done), .pc_rdata(pc_rdata),
    .acc_data(acc_data), .mag_data(mag_data), .err(err)
  );

  always #5 FSM_Clk = ~FSM_Clk;

  int errors = 0;
  int checks = 0;

  bit          engRespond = 1'b1;
  bit          engNack = 1'b0;
  int          engDelay = 5;
  logic [31:0] engData = '0;

  // Engine model: done appears in cycle start+engDelay for one cycle.
  initial begin
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = '0;
    forever begin
      @(negedge FSM_Clk);
      bus.i2c_done = 1'b0;
      if (bus.i2c_start === 1'b1 && engRespond) begin
        for (int k = 0; k < engDelay; k++) @(negedge FSM_Clk);
        bus.i2c_done  = 1'b1;
        bus.i2c_nack  = engNack;
        bus.i2c_rdata = engData;
      end
    end
  end

  // Iteration c observes the cycle c after the call's starting negedge.
  task automatic waitStart(input int maxCyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc = -1;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge FSM_Clk);
      if (bus.i2c_start === 1'b1) begin
        seen = 1'b1;
        cyc = c;
        $display("txn start: slave=%h sub=%h rw=%b wdata=%h nbytes=%0d",
                 bus.i2c_slave, bus.i2c_sub, bus.i2c_rw, bus.i2c_wdata, bus.i2c_nbytes);
        break;
      end
    end
  endtask

  task automatic waitPcDone(input int maxCyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc = -1;
    for (int c = 1; c <= maxCyc; c++) begin
      @(negedge FSM_Clk);
      if (pc_done === 1'b1) begin
        seen = 1'b1;
        cyc = c;
        $display("txn pc_done: pc_rdata=%h err=%b", pc_rdata, err);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge FSM_Clk);
    checks++; if (bus.i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.i2c_start); end
    checks++; if (bus.i2c_slave !== 7'h00) begin errors++; $display("FAIL reset_slave: got %h want 00", bus.i2c_slave); end
    checks++; if (pc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", pc_busy); end
    checks++; if (pc_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", pc_done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
    checks++; if (acc_data !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", acc_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_poll();
    int cyc; bit seen;
    engRespond = 1'b1; engNack = 1'b0; engDelay = 5; engData = 32'h11223344;
    poll_en = 1'b1;
    waitStart(20, cyc, seen);
    checks++; if (!seen || cyc != 8) begin errors++; $display("FAIL poll_start_cycle: got %0d want 8", cyc); end
    checks++; if (bus.i2c_slave !== 7'h19) begin errors++; $display("FAIL poll_acc_slave: got %h want 19", bus.i2c_slave); end
    checks++; if (bus.i2c_sub !== 7'h28) begin errors++; $display("FAIL poll_acc_sub: got %h want 28", bus.i2c_sub); end
    checks++; if (bus.i2c_nbytes !== 8'd4) begin errors++; $display("FAIL poll_nbytes: got %0d want 4", bus.i2c_nbytes); end
    checks++; if (bus.i2c_rw !== 1'b1 || bus.i2c_wdata !== 8'h00) begin errors++; $display("FAIL poll_rw_wdata: got %b/%h want 1/00", bus.i2c_rw, bus.i2c_wdata); end
    // done in cycle 13, capture 14, visible in cycle 15
    repeat (7) @(negedge FSM_Clk);
    checks++; if (acc_data !== 32'h11223344) begin errors++; $display("FAIL poll_acc_data: got %h want 11223344", acc_data); end
    engData = 32'hAABBCCDD;
    waitStart(4, cyc, seen);
    checks++; if (!seen || cyc != 0) begin errors++; $display("FAIL poll_mag_cycle: got %0d want 0", cyc); end
    checks++; if (bus.i2c_slave !== 7'h1E || bus.i2c_sub !== 7'h03) begin errors++; $display("FAIL poll_mag_addr: got %h/%h want 1e/03", bus.i2c_slave, bus.i2c_sub); end
    poll_en = 1'b0;
    repeat (7) @(negedge FSM_Clk);
    checks++; if (mag_data !== 32'hAABBCCDD) begin errors++; $display("FAIL poll_mag_data: got %h want aabbccdd", mag_data); end
  endtask

  task automatic test_pc_priority();
    int cyc; bit seen;
    engDelay = 3; engData = 32'h99999999;
    poll_en = 1'b1;
    repeat (7) @(negedge FSM_Clk);
    // cycle 6: PC edge is sampled at the same edge that sets poll_pend
    PCControl = 1'b1; pc_slave = 7'h2A; pc_sub = 7'h10; pc_rw = 1'b0;
    pc_wdata = 8'h5A; pc_nbytes = 8'd2;
    waitStart(6, cyc, seen);
    checks++; if (!seen || cyc != 1) begin errors++; $display("FAIL prio_start_cycle: got %0d want 1", cyc); end
    checks++; if (bus.i2c_slave !== 7'h2A || bus.i2c_sub !== 7'h10) begin errors++; $display("FAIL prio_pc_first: got %h/%h want 2a/10", bus.i2c_slave, bus.i2c_sub); end
    checks++; if (bus.i2c_rw !== 1'b0 || bus.i2c_wdata !== 8'h5A || bus.i2c_nbytes !== 8'd2) begin errors++; $display("FAIL prio_pc_fields: got %b/%h/%0d want 0/5a/2", bus.i2c_rw, bus.i2c_wdata, bus.i2c_nbytes); end
    checks++; if (pc_busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b want 1", pc_busy); end
    waitPcDone(10, cyc, seen);
    checks++; if (!seen || cyc != 5) begin errors++; $display("FAIL prio_pc_done: got %0d want 5", cyc); end
    checks++; if (pc_busy !== 1'b0) begin errors++; $display("FAIL prio_busy_end: got %b want 0", pc_busy); end
    engData = 32'h0BADCAFE;
    waitStart(1, cyc, seen);
    checks++; if (!seen || bus.i2c_slave !== 7'h19) begin errors++; $display("FAIL prio_poll_follows: got seen=%b slave=%h want 1/19", seen, bus.i2c_slave); end
    poll_en = 1'b0;
    PCControl = 1'b0;
    repeat (6) @(negedge FSM_Clk);
    checks++; if (acc_data !== 32'h0BADCAFE) begin errors++; $display("FAIL prio_acc_data: got %h want 0badcafe", acc_data); end
    checks++; if (pc_rdata !== 32'h0) begin errors++; $display("FAIL prio_write_no_rdata: got %h want 0", pc_rdata); end
  endtask

  task automatic test_clamp();
    logic [7:0]  nIn [3];
    logic [7:0]  nExp [3];
    logic [31:0] dat [3];
    int cyc; bit seen;
    nIn = '{8'd0, 8'd9, 8'd3};
    nExp = '{8'd1, 8'd4, 8'd3};
    dat = '{32'hCAFEF00D, 32'h01020304, 32'hA5A5A5A5};
    engDelay = 2;
    for (int i = 0; i < 3; i++) begin
      engData = dat[i];
      PCControl = 1'b1; pc_slave = 7'h33; pc_sub = 7'h01; pc_rw = 1'b1; pc_nbytes = nIn[i];
      waitStart(5, cyc, seen);
      checks++; if (!seen || bus.i2c_nbytes !== nExp[i]) begin errors++; $display("FAIL clamp_nbytes[%0d]: got %0d want %0d", i, bus.i2c_nbytes, nExp[i]); end
      waitPcDone(10, cyc, seen);
      checks++; if (!seen || pc_rdata !== dat[i]) begin errors++; $display("FAIL clamp_rdata[%0d]: got %h want %h", i, pc_rdata, dat[i]); end
      PCControl = 1'b0;
      @(negedge FSM_Clk);
    end
  endtask

  task automatic test_nack();
    int cyc; bit seen;
    engNack = 1'b1; engDelay = 2; engData = 32'hDEADBEEF;
    poll_en = 1'b1;
    waitStart(12, cyc, seen);
    checks++; if (!seen || bus.i2c_slave !== 7'h1E) begin errors++; $display("FAIL nack_mag_target: got %h want 1e", bus.i2c_slave); end
    poll_en = 1'b0;
    repeat (4) @(negedge FSM_Clk);
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL nack_err: got %b want 01", err); end
    checks++; if (mag_data !== 32'hAABBCCDD) begin errors++; $display("FAIL nack_mag_kept: got %h want aabbccdd", mag_data); end
    engNack = 1'b0; engData = 32'h55667788;
    poll_en = 1'b1;
    waitStart(12, cyc, seen);
    checks++; if (!seen || bus.i2c_slave !== 7'h19) begin errors++; $display("FAIL nack_next_acc: got %h want 19", bus.i2c_slave); end
    poll_en = 1'b0;
    repeat (4) @(negedge FSM_Clk);
    checks++; if (acc_data !== 32'h55667788) begin errors++; $display("FAIL nack_acc_after: got %h want 55667788", acc_data); end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL nack_sticky: got %b want 01", err); end
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    engRespond = 1'b0;
    PCControl = 1'b1; pc_slave = 7'h44; pc_sub = 7'h02; pc_rw = 1'b1; pc_nbytes = 8'd4;
    waitStart(5, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_start: got none want start"); end
    waitPcDone(30, cyc, seen);
    checks++; if (!seen || cyc != 16) begin errors++; $display("FAIL timeout_done_cycle: got %0d want 16", cyc); end
    checks++; if (err !== 2'b10) begin errors++; $display("FAIL timeout_err: got %b want 10", err); end
    PCControl = 1'b0;
    @(negedge FSM_Clk);
    engRespond = 1'b1; engDelay = 2; engData = 32'h0;
    PCControl = 1'b1;
    @(negedge FSM_Clk);
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL timeout_err_clear: got %b want 00", err); end
    waitPcDone(12, cyc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL timeout_followup_done: got none want pulse"); end
    PCControl = 1'b0;
    @(negedge FSM_Clk);
  endtask

  task automatic test_reset_midflight();
    int cyc; bit seen; bit doneSeen;
    engRespond = 1'b0;
    PCControl = 1'b1; pc_slave = 7'h55; pc_sub = 7'h07; pc_rw = 1'b1; pc_nbytes = 8'd1;
    waitStart(5, cyc, seen);
    repeat (3) @(negedge FSM_Clk);
    checks++; if (pc_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", pc_busy); end
    @(posedge FSM_Clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc_busy !== 1'b0 || bus.i2c_slave !== 7'h00 || bus.i2c_nbytes !== 8'h00) begin errors++; $display("FAIL rst_async_bus: got busy=%b slave=%h nbytes=%h want 0", pc_busy, bus.i2c_slave, bus.i2c_nbytes); end
    checks++; if (acc_data !== 32'h0 || mag_data !== 32'h0 || pc_rdata !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h/%h/%h want 0", acc_data, mag_data, pc_rdata); end
    PCControl = 1'b0;
    doneSeen = 1'b0;
    repeat (3) begin
      @(negedge FSM_Clk);
      if (pc_done === 1'b1) doneSeen = 1'b1;
    end
    rst_n = 1'b1;
    engRespond = 1'b1; engDelay = 2;
    poll_en = 1'b1;
    cyc = -1;
    for (int c = 0; c < 13; c++) begin
      @(negedge FSM_Clk);
      if (pc_done === 1'b1) doneSeen = 1'b1;
      if (bus.i2c_start === 1'b1 && cyc < 0) begin
        cyc = c;
        $display("txn start after reset: slave=%h sub=%h", bus.i2c_slave, bus.i2c_sub);
        checks++; if (bus.i2c_slave !== 7'h19) begin errors++; $display("FAIL rst_first_acc: got %h want 19", bus.i2c_slave); end
      end
    end
    checks++; if (cyc != 8) begin errors++; $display("FAIL rst_poll_cycle: got %0d want 8", cyc); end
    checks++; if (doneSeen !== 1'b0) begin errors++; $display("FAIL rst_no_pc_done: got %b want 0", doneSeen); end
    poll_en = 1'b0;
    repeat (6) @(negedge FSM_Clk);
  endtask

  initial begin
    test_reset();
    test_poll();
    test_pc_priority();
    test_clamp();
    test_nack();
    test_timeout();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
